// File: rtl/wb_retire_monitor.sv
// Retire-side observer for the writeback stage: cycle/instret counters, last
// register write, halt-then-drain end detection and a cycle watchdog.
module wb_retire_monitor #(
    parameter int         MAX_CYCLES   = 500,
    parameter int         DRAIN_CYCLES = 1,
    parameter logic [6:0] HALT_TYPE    = 7'd7,
    parameter int         CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             WB_V,
    input  logic [6:0]       WB_TYPE,
    input  logic [31:0]      WB_PC,
    input  logic             WB_WE,
    input  logic [4:0]       WB_RD,
    input  logic [31:0]      WB_WDATA,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTRET_CNT,
    output logic [31:0]      LAST_PC,
    output logic [4:0]       LAST_RD,
    output logic [31:0]      LAST_WDATA,
    output logic             HALTED,
    output logic             TIMEOUT,
    output logic             DONE
);

    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_TOUT} state_e;

    state_e           state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [4:0]       last_rd_q, last_rd_d;
    logic [31:0]      last_wdata_q, last_wdata_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] instret_inc;
    logic             is_halt;

    always_comb begin
        cycle_inc   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        instret_inc = (instret_cnt_q == '1) ? instret_cnt_q : instret_cnt_q + CNT_W'(1);
        // WB_V gates WB_TYPE so an undriven type on a bubble never halts
        is_halt     = WB_V && (WB_TYPE == HALT_TYPE);
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        last_pc_d     = last_pc_q;
        last_rd_d     = last_rd_q;
        last_wdata_d  = last_wdata_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        done_d        = done_q;

        if (CLR) begin
            state_d       = S_RUN;
            drain_cnt_d   = '0;
            cycle_cnt_d   = '0;
            instret_cnt_d = '0;
            last_pc_d     = '0;
            last_rd_d     = '0;
            last_wdata_d  = '0;
            halted_d      = 1'b0;
            timeout_d     = 1'b0;
            done_d        = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cycle_cnt_d = cycle_inc;
                    if (WB_V) begin
                        instret_cnt_d = instret_inc;
                        last_pc_d     = WB_PC;
                    end
                    if (WB_V && WB_WE && (WB_RD != 5'd0)) begin
                        last_rd_d    = WB_RD;
                        last_wdata_d = WB_WDATA;
                    end
                    // halt outranks a watchdog expiry on the same edge
                    if (is_halt) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = DCW'(DRAIN_CYCLES);
                        end
                    end else if ((MAX_CYCLES != 0) && (cycle_inc == MAX_C)) begin
                        state_d   = S_TOUT;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
                S_DRAIN: begin
                    cycle_cnt_d = cycle_inc;
                    if (drain_cnt_q == DCW'(1)) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_RUN;
            drain_cnt_q   <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            last_pc_q     <= '0;
            last_rd_q     <= '0;
            last_wdata_q  <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
            last_pc_q     <= last_pc_d;
            last_rd_q     <= last_rd_d;
            last_wdata_q  <= last_wdata_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
        end
    end

    assign CYCLE_CNT   = cycle_cnt_q;
    assign INSTRET_CNT = instret_cnt_q;
    assign LAST_PC     = last_pc_q;
    assign LAST_RD     = last_rd_q;
    assign LAST_WDATA  = last_wdata_q;
    assign HALTED      = halted_q;
    assign TIMEOUT     = timeout_q;
    assign DONE        = done_q;

endmodule
